sdram_refresh_arbiter: RTL and testbench



---
 rtl/sdram_arb_pkg.sv | 29 ++
 rtl/sdram_refresh_arbiter_refresh_timer.sv | 48 ++++
 rtl/sdram_refresh_arbiter.sv | 98 +++++++++
 tb/tb_sdram_refresh_arbiter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared state encoding, parameter defaults and debt arithmetic for sdram_refresh_arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BUS     = 2'b01,
        REFRESH = 2'b10,
        RECOVER = 2'b11
    } arb_state_e;

    localparam int unsigned DEF_REFRESH_INTERVAL = 780;
    localparam int unsigned DEF_MAX_DEBT         = 7;
    localparam int unsigned DEF_TRFC             = 7;

    // Tick and issue together cancel; a tick at the limit saturates.
    function automatic logic [3:0] debt_next(input logic [3:0] debt,
                                             input logic       tick,
                                             input logic       issue,
                                             input logic [3:0] max_debt);
        logic [3:0] r;
        r = debt;
        if (tick && !issue && (debt != max_debt))
            r = debt + 4'd1;
        else if (issue && !tick && (debt != 4'd0))
            r = debt - 4'd1;
        return r;
    endfunction

endpackage

// File: rtl/sdram_refresh_arbiter_refresh_timer.sv
// Refresh interval counter plus owed-refresh debt counter and sticky overrun flag.
module refresh_timer
    import sdram_arb_pkg::*;
#(
    parameter int unsigned REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
    parameter int unsigned MAX_DEBT         = DEF_MAX_DEBT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue,
    output logic [3:0] debt,
    output logic       urgent,
    output logic       overrun
);

    localparam int unsigned   IW     = $clog2(REFRESH_INTERVAL + 1);
    localparam logic [IW-1:0] RELOAD = IW'(REFRESH_INTERVAL - 1);
    localparam logic [3:0]    MAXD   = 4'(MAX_DEBT);

    logic [IW-1:0] intv_q, intv_d;
    logic [3:0]    debt_q, debt_d;
    logic          ovr_q, ovr_d;
    logic          tick;

    always_comb begin
        tick   = (intv_q == '0);
        intv_d = tick ? RELOAD : intv_q - IW'(1);
        debt_d = debt_next(debt_q, tick, issue, MAXD);
        ovr_d  = ovr_q | (tick & (debt_q == MAXD));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            intv_q <= RELOAD;
            debt_q <= '0;
            ovr_q  <= 1'b0;
        end else begin
            intv_q <= intv_d;
            debt_q <= debt_d;
            ovr_q  <= ovr_d;
        end
    end

    assign debt    = debt_q;
    assign urgent  = (debt_q == MAXD);
    assign overrun = ovr_q;

endmodule

// File: rtl/sdram_refresh_arbiter.sv
// Arbitrates the SDRAM command port between Zorro II bus accesses and auto-refresh.
// Define REFRESH_BURST_EN to chain refreshes straight out of RECOVER while the bus is idle.
module sdram_refresh_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
    parameter int unsigned MAX_DEBT         = DEF_MAX_DEBT,
    parameter int unsigned TRFC             = DEF_TRFC
) (
    input  logic       MEMCLK,
    input  logic       RESET,
    input  logic       bus_req,
    input  logic       bus_done,
    output logic       bus_gnt,
    output logic       ref_cmd,
    output logic [3:0] debt,
    output logic       overrun
);

    localparam int unsigned RW = $clog2(TRFC + 1);

    arb_state_e    state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          bus_gnt_q, bus_gnt_d;
    logic          ref_cmd_q, ref_cmd_d;
    logic          urgent;
    logic          issue;

    assign issue = (state_q == REFRESH);

    refresh_timer #(
        .REFRESH_INTERVAL(REFRESH_INTERVAL),
        .MAX_DEBT        (MAX_DEBT)
    ) u_timer (
        .clk    (MEMCLK),
        .rst    (RESET),
        .issue  (issue),
        .debt   (debt),
        .urgent (urgent),
        .overrun(overrun)
    );

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            IDLE: begin
                if (urgent)
                    state_d = REFRESH;
                else if (bus_req)
                    state_d = BUS;
                else if (debt != 4'd0)
                    state_d = REFRESH;
            end
            BUS: begin
                if (bus_done)
                    state_d = IDLE;
            end
            REFRESH: begin
                state_d = RECOVER;
                rcnt_d  = RW'(TRFC - 2);
            end
            RECOVER: begin
                if (rcnt_q == '0) begin
`ifdef REFRESH_BURST_EN
                    state_d = ((debt != 4'd0) && !bus_req) ? REFRESH : IDLE;
`else
                    state_d = IDLE;
`endif
                end else begin
                    rcnt_d = rcnt_q - RW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are decoded from the next state so they register alongside it.
        bus_gnt_d = (state_d == BUS);
        ref_cmd_d = (state_d == REFRESH);
    end

    always_ff @(posedge MEMCLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            rcnt_q    <= '0;
            bus_gnt_q <= 1'b0;
            ref_cmd_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            bus_gnt_q <= bus_gnt_d;
            ref_cmd_q <= ref_cmd_d;
        end
    end

    assign bus_gnt = bus_gnt_q;
    assign ref_cmd = ref_cmd_q;

endmodule

// File: tb/tb_sdram_refresh_arbiter.sv
// Directed vector bench for sdram_refresh_arbiter (REFRESH_INTERVAL=16, MAX_DEBT=3, TRFC=4).
module tb_sdram_refresh_arbiter;

    logic       MEMCLK = 1'b0;
    logic       RESET  = 1'b1;
    logic       bus_req = 1'b0;
    logic       bus_done = 1'b0;
    logic       bus_gnt;
    logic       ref_cmd;
    logic [3:0] debt;
    logic       overrun;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

`ifdef REFRESH_BURST_EN
    localparam int unsigned SPACING = 4;
`else
    localparam int unsigned SPACING = 5;
`endif

    sdram_refresh_arbiter #(
        .REFRESH_INTERVAL(16),
        .MAX_DEBT        (3),
        .TRFC            (4)
    ) dut (
        .MEMCLK  (MEMCLK),
        .RESET   (RESET),
        .bus_req (bus_req),
        .bus_done(bus_done),
        .bus_gnt (bus_gnt),
        .ref_cmd (ref_cmd),
        .debt    (debt),
        .overrun (overrun)
    );

    always #5 MEMCLK = ~MEMCLK;

    typedef struct {
        logic        rst;
        logic        req;
        logic        done;
        int unsigned hold;
        logic        gnt_exp;
        logic        ref_exp;
        logic [3:0]  debt_exp;
        logic        ovr_exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic rst, logic req, logic done, int unsigned hold,
                                logic g, logic r, logic [3:0] d, logic o, string name);
        vec_t v;
        v.rst = rst; v.req = req; v.done = done; v.hold = hold;
        v.gnt_exp = g; v.ref_exp = r; v.debt_exp = d; v.ovr_exp = o; v.name = name;
        vecs.push_back(v);
    endfunction

    // Drive inputs away from the edge, run n rising edges, settle just after the last.
    task automatic step(input logic rst, input logic req, input logic done, input int unsigned n);
        @(negedge MEMCLK);
        RESET = rst; bus_req = req; bus_done = done;
        repeat (n) @(posedge MEMCLK);
        #1;
    endtask

    task automatic check_out(input string name, input logic g, input logic r,
                             input logic [3:0] d, input logic o);
        n_vec++;
        if (bus_gnt !== g || ref_cmd !== r || debt !== d || overrun !== o) begin
            n_miss++;
            $display("FAIL %s: gnt/ref/debt/ovr got %b/%b/%0d/%b want %b/%b/%0d/%b",
                     name, bus_gnt, ref_cmd, debt, overrun, g, r, d, o);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    initial begin
        int ref_at[$];

        //   rst req done hold  gnt ref debt ovr
        add(1, 0, 0,  2,  0, 0, 0, 0, "reset_state");
        add(0, 0, 0, 15,  0, 0, 0, 0, "before_tick1");
        add(0, 0, 0,  1,  0, 0, 1, 0, "tick1_debt");
        add(0, 0, 0,  1,  0, 1, 1, 0, "ref1_pulse");
        add(0, 0, 0,  1,  0, 0, 0, 0, "ref1_drained");
        add(0, 0, 1, 14,  0, 0, 1, 0, "tick2_done_ignored");
        add(0, 0, 0,  1,  0, 1, 1, 0, "ref2_pulse");
        add(0, 0, 0,  1,  0, 0, 0, 0, "ref2_drained");
        add(0, 1, 0,  3,  0, 0, 0, 0, "req_held_in_recover");
        add(0, 1, 0,  1,  1, 0, 0, 0, "grant_after_recover");
        add(0, 1, 0, 10,  1, 0, 1, 0, "bus_debt1");
        add(0, 1, 0, 16,  1, 0, 2, 0, "bus_debt2");
        add(0, 1, 0, 16,  1, 0, 3, 0, "bus_debt3");
        add(0, 1, 0, 16,  1, 0, 3, 1, "overrun_set");
        add(0, 1, 0,  4,  1, 0, 3, 1, "overrun_sticky");
        add(0, 1, 1,  1,  0, 0, 3, 1, "done_drops_gnt");
        add(0, 1, 0,  1,  0, 1, 3, 1, "urgent_beats_req");
        add(0, 1, 0,  1,  0, 0, 2, 1, "urgent_debt_dec");
        add(0, 1, 0,  3,  0, 0, 2, 1, "recover_no_gnt");
        add(0, 1, 0,  1,  1, 0, 2, 1, "gnt_trfc_plus1");
        add(1, 1, 0,  1,  0, 0, 0, 0, "reset_mid_bus");
        add(0, 0, 0, 15,  0, 0, 0, 0, "restart_before_tick");
        add(0, 0, 0,  1,  0, 0, 1, 0, "restart_tick");
        add(0, 0, 0,  1,  0, 1, 1, 0, "restart_ref");
        add(0, 0, 0,  1,  0, 0, 0, 0, "restart_recover");
        add(1, 0, 0,  1,  0, 0, 0, 0, "reset_mid_recover");
        add(0, 0, 0, 15,  0, 0, 0, 0, "restart2_before_tick");
        add(0, 0, 0,  1,  0, 0, 1, 0, "restart2_tick");
        add(0, 0, 0,  1,  0, 1, 1, 0, "restart2_ref");

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].done, vecs[i].hold);
            check_out(vecs[i].name, vecs[i].gnt_exp, vecs[i].ref_exp,
                      vecs[i].debt_exp, vecs[i].ovr_exp);
        end

        // Back-to-back grants, then drain a full debt with the bus idle.
        step(1, 0, 0, 2);
        step(0, 1, 0, 1);
        check_out("b2b_first_gnt", 1, 0, 0, 0);
        step(0, 1, 1, 1);
        check_out("b2b_idle_gap", 0, 0, 0, 0);
        step(0, 1, 0, 1);
        check_out("b2b_second_gnt", 1, 0, 0, 0);
        step(0, 1, 0, 45);
        check_out("burst_debt_full", 1, 0, 3, 0);
        step(0, 1, 0, 1);
        step(0, 0, 1, 1);
        check_out("burst_bus_released", 0, 0, 3, 0);
        for (int e = 51; e <= 63; e++) begin
            step(0, 0, 0, 1);
            if (ref_cmd) ref_at.push_back(e);
        end
        check_int("drain_ref_count", ref_at.size(), 3);
        if (ref_at.size() == 3) begin
            check_int("drain_first_ref", ref_at[0], 51);
            check_int("drain_gap1", ref_at[1] - ref_at[0], SPACING);
            check_int("drain_gap2", ref_at[2] - ref_at[1], SPACING);
        end
        check_out("drain_debt_zero", 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
